// File: rtl/perf_event_counter.sv
// Performance event counters (cycle, instr, branch, mispredict) with overflow handling,
// a shadow snapshot bank and an end-of-test detector that freezes counting and latches pass/fail.
module perf_event_counter #(
    parameter int          COMMIT_W = 2,
    parameter int          CNT_W    = 32,
    parameter int          SAT      = 0,
    parameter logic [31:0] END_CODE = 32'h5D
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [COMMIT_W-1:0] commit_valid_i,
    input  logic [COMMIT_W-1:0] commit_flushed_i,
    input  logic [COMMIT_W-1:0] commit_branch_i,
    input  logic                mispredict_i,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic                snap_i,
    input  logic [31:0]         a7_i,
    input  logic [31:0]         a0_i,
    input  logic [1:0]          sel_i,
    output logic [CNT_W-1:0]    rd_data_o,
    output logic [3:0]          ovf_o,
    output logic [1:0]          state_o,
    output logic                done_o,
    output logic                pass_o
);
    localparam int INC_W = $clog2(COMMIT_W + 1);
    localparam int NCNT  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q    [NCNT];
    logic [CNT_W-1:0] cnt_d    [NCNT];
    logic [CNT_W-1:0] shadow_q [NCNT];
    logic [CNT_W-1:0] shadow_d [NCNT];
    logic [3:0]       ovf_q, ovf_d;
    logic             pass_q, pass_d;

    logic [INC_W-1:0] instr_inc, br_inc;
    logic [CNT_W-1:0] inc    [NCNT];
    logic [CNT_W:0]   sum    [NCNT];
    logic [CNT_W-1:0] bumped [NCNT];
    logic             count_en, end_hit;

    always_comb begin
        instr_inc = '0;
        br_inc    = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            instr_inc += INC_W'(commit_valid_i[i] & ~commit_flushed_i[i]);
            br_inc    += INC_W'(commit_valid_i[i] & ~commit_flushed_i[i] & commit_branch_i[i]);
        end
    end

    assign inc[0] = CNT_W'(1'b1);
    assign inc[1] = CNT_W'(instr_inc);
    assign inc[2] = CNT_W'(br_inc);
    assign inc[3] = CNT_W'(mispredict_i);

    // One extra sum bit exposes the carry that flags overflow in both modes.
    for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
        assign sum[gi]    = {1'b0, cnt_q[gi]} + {1'b0, inc[gi]};
        assign bumped[gi] = ((SAT != 0) && sum[gi][CNT_W]) ? {CNT_W{1'b1}} : sum[gi][CNT_W-1:0];
    end

    assign count_en = (state_q == RUN) && en_i;
    assign end_hit  = (state_q == RUN) && (a7_i == END_CODE);

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q;
        pass_d  = pass_q;
        for (int k = 0; k < NCNT; k++) begin
            cnt_d[k]    = cnt_q[k];
            shadow_d[k] = shadow_q[k];
        end

        if (count_en) begin
            for (int k = 0; k < NCNT; k++) begin
                cnt_d[k] = bumped[k];
                if (sum[k][CNT_W]) ovf_d[k] = 1'b1;
            end
        end

        case (state_q)
            IDLE:    if (en_i) state_d = RUN;
            RUN:     if (!en_i) state_d = IDLE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Shadow captures post-increment values so the final cycle is included.
        if (end_hit) begin
            state_d = DONE;
            pass_d  = (a0_i == 32'd0);
            for (int k = 0; k < NCNT; k++) shadow_d[k] = cnt_d[k];
        end else if (snap_i && (state_q != DONE)) begin
            for (int k = 0; k < NCNT; k++) shadow_d[k] = cnt_d[k];
        end

        if (clr_i) begin
            state_d = IDLE;
            ovf_d   = '0;
            pass_d  = 1'b0;
            for (int k = 0; k < NCNT; k++) begin
                cnt_d[k]    = '0;
                shadow_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ovf_q   <= '0;
            pass_q  <= 1'b0;
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            pass_q  <= pass_d;
            for (int k = 0; k < NCNT; k++) begin
                cnt_q[k]    <= cnt_d[k];
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    assign rd_data_o = shadow_q[sel_i];
    assign ovf_o     = ovf_q;
    assign state_o   = state_q;
    assign done_o    = (state_q == DONE);
    assign pass_o    = pass_q;
endmodule

// File: tb/tb_perf_event_counter.sv
// Self-checking bench: a 32-bit wrapping instance plus 8-bit wrapping and saturating instances
// share stimulus; directed tables/sequences plus a random run against an arithmetic model.
module tb_perf_event_counter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  v = '0, f = '0, b = '0;
    logic        mis = 1'b0, en = 1'b0, clr = 1'b0, snap = 1'b0;
    logic [31:0] a7 = '0, a0 = '0;
    logic [1:0]  sel = '0;

    logic [31:0] rd0;
    logic [7:0]  rd1, rd2;
    logic [3:0]  ovf0, ovf1, ovf2;
    logic [1:0]  st0, st1, st2;
    logic        done0, done1, done2, pass0, pass1, pass2;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    perf_event_counter u_dut (
        .clk(clk), .rst_n(rst_n), .commit_valid_i(v), .commit_flushed_i(f), .commit_branch_i(b),
        .mispredict_i(mis), .en_i(en), .clr_i(clr), .snap_i(snap), .a7_i(a7), .a0_i(a0),
        .sel_i(sel), .rd_data_o(rd0), .ovf_o(ovf0), .state_o(st0), .done_o(done0), .pass_o(pass0)
    );

    perf_event_counter #(.CNT_W(8), .SAT(0)) u_w8 (
        .clk(clk), .rst_n(rst_n), .commit_valid_i(v), .commit_flushed_i(f), .commit_branch_i(b),
        .mispredict_i(mis), .en_i(en), .clr_i(clr), .snap_i(snap), .a7_i(a7), .a0_i(a0),
        .sel_i(sel), .rd_data_o(rd1), .ovf_o(ovf1), .state_o(st1), .done_o(done1), .pass_o(pass1)
    );

    perf_event_counter #(.CNT_W(8), .SAT(1)) u_s8 (
        .clk(clk), .rst_n(rst_n), .commit_valid_i(v), .commit_flushed_i(f), .commit_branch_i(b),
        .mispredict_i(mis), .en_i(en), .clr_i(clr), .snap_i(snap), .a7_i(a7), .a0_i(a0),
        .sel_i(sel), .rd_data_o(rd2), .ovf_o(ovf2), .state_o(st2), .done_o(done2), .pass_o(pass2)
    );

    typedef struct {
        logic        en;
        logic [1:0]  v;
        logic [1:0]  f;
        logic [1:0]  b;
        logic        mis;
        logic        snap;
        logic [1:0]  sel;
        logic [31:0] exp_rd;
        logic [1:0]  exp_st;
    } vec_t;
    vec_t tbl[$];

    // Reference model: per instance counters as plain integers, shared FSM state.
    int     mw[3] = '{32, 8, 8};
    int     ms[3] = '{0, 0, 1};
    longint m_cnt[3][4];
    longint m_sh[3][4];
    logic [3:0] m_ovf[3];
    int     m_st;
    logic   m_pass;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        v = '0; f = '0; b = '0; mis = 0; en = 0; clr = 0; snap = 0; a7 = '0; a0 = '0;
    endtask

    task automatic add(input logic e, input logic [1:0] vv, input logic [1:0] ff, input logic [1:0] bb,
                       input logic m, input logic s, input logic [1:0] sl,
                       input logic [31:0] er, input logic [1:0] es);
        tbl.push_back('{e, vv, ff, bb, m, s, sl, er, es});
    endtask

    task automatic model_step();
        longint inc[4];
        longint lim;
        longint s;
        int nxt;
        if (clr) begin
            for (int d = 0; d < 3; d++) begin
                m_ovf[d] = '0;
                for (int k = 0; k < 4; k++) begin
                    m_cnt[d][k] = 0;
                    m_sh[d][k] = 0;
                end
            end
            m_st = 0;
            m_pass = 0;
            return;
        end
        inc[0] = 1;
        inc[1] = $countones(v & ~f);
        inc[2] = $countones(v & ~f & b);
        inc[3] = mis;
        if (m_st == 1 && en) begin
            for (int d = 0; d < 3; d++) begin
                lim = longint'(1) << mw[d];
                for (int k = 0; k < 4; k++) begin
                    s = m_cnt[d][k] + inc[k];
                    if (s >= lim) begin
                        m_ovf[d][k] = 1'b1;
                        s = (ms[d] != 0) ? lim - 1 : s - lim;
                    end
                    m_cnt[d][k] = s;
                end
            end
        end
        nxt = m_st;
        if (m_st == 0 && en) nxt = 1;
        if (m_st == 1 && !en) nxt = 0;
        if (m_st == 1 && a7 == 32'h5D) begin
            nxt = 2;
            m_pass = (a0 == 0);
            for (int d = 0; d < 3; d++) for (int k = 0; k < 4; k++) m_sh[d][k] = m_cnt[d][k];
        end else if (snap && m_st != 2) begin
            for (int d = 0; d < 3; d++) for (int k = 0; k < 4; k++) m_sh[d][k] = m_cnt[d][k];
        end
        m_st = nxt;
    endtask

    task automatic chk_dut(input int d, input logic [63:0] rd, input logic [3:0] ov,
                           input logic [1:0] st, input logic dn, input logic ps);
        chk($sformatf("rnd%0d_rd_sel%0d", d, sel), rd, 64'(m_sh[d][sel]));
        chk($sformatf("rnd%0d_ovf", d), 64'(ov), 64'(m_ovf[d]));
        chk($sformatf("rnd%0d_state", d), 64'(st), 64'(m_st));
        chk($sformatf("rnd%0d_done", d), 64'(dn), 64'(m_st == 2));
        chk($sformatf("rnd%0d_pass", d), 64'(ps), 64'(m_pass));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_state", 64'(st0), 0);
        chk("rst_done", 64'(done0), 0);
        chk("rst_pass", 64'(pass0), 0);
        chk("rst_ovf", 64'(ovf0), 0);
        chk("rst_rd", 64'(rd0), 0);
        #10 rst_n = 1'b1;

        // Count-and-report then flush masking, as a vector table
        add(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'd0, 0, 2'd1);
        for (int c = 1; c <= 10; c++)
            add(1, 2'b11, 2'b00, (c <= 3) ? 2'b01 : 2'b00, (c == 4 || c == 5), 0, 2'(c % 4), 0, 2'd1);
        add(0, 2'b00, 2'b00, 2'b00, 0, 1, 2'd0, 10, 2'd0);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'd1, 20, 2'd0);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'd2, 3, 2'd0);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'd3, 2, 2'd0);
        add(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'd1, 20, 2'd1);
        for (int c = 0; c < 4; c++) add(1, 2'b11, 2'b10, 2'b00, 0, 0, 2'd1, 20, 2'd1);
        add(0, 2'b00, 2'b00, 2'b00, 0, 1, 2'd1, 24, 2'd0);
        add(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'd0, 14, 2'd1);
        for (int c = 0; c < 3; c++) add(1, 2'b01, 2'b01, 2'b01, 0, 0, 2'd0, 14, 2'd1);
        add(0, 2'b00, 2'b00, 2'b00, 0, 1, 2'd1, 24, 2'd0);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'd0, 17, 2'd0);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'd2, 3, 2'd0);
        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en; v = tbl[i].v; f = tbl[i].f; b = tbl[i].b;
            mis = tbl[i].mis; snap = tbl[i].snap; sel = tbl[i].sel;
            step();
            chk($sformatf("tbl%0d_rd", i), 64'(rd0), 64'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d_state", i), 64'(st0), 64'(tbl[i].exp_st));
        end

        // Overflow on the 8-bit instances: reach 254, then two more double commits
        quiet(); clr = 1; step(); clr = 0;
        en = 1; step();
        v = 2'b11;
        repeat (127) step();
        chk("ovf_before_w8", 64'(ovf1[1]), 0);
        repeat (2) step();
        v = 2'b00; snap = 1; sel = 2'd1; step(); snap = 0;
        chk("ovf_instr_w8", 64'(rd1), 2);
        chk("ovf_instr_s8", 64'(rd2), 255);
        chk("ovf_instr_32", 64'(rd0), 258);
        chk("ovf_flag_w8", 64'(ovf1), 64'(4'b0010));
        chk("ovf_flag_s8", 64'(ovf2), 64'(4'b0010));
        v = 2'b11; repeat (3) step();
        chk("ovf_sticky_w8", 64'(ovf1[1]), 1);
        chk("ovf_sticky_s8", 64'(ovf2[1]), 1);
        quiet(); clr = 1; step(); clr = 0;
        chk("ovf_clr_w8", 64'(ovf1), 0);
        chk("ovf_clr_s8", 64'(ovf2), 0);
        chk("ovf_clr_rd", 64'(rd2), 0);

        // End of test, passing
        en = 1; step();
        v = 2'b11; a7 = 32'h5D; a0 = 0; step();
        chk("eot_done", 64'(done0), 1);
        chk("eot_pass", 64'(pass0), 1);
        chk("eot_state", 64'(st0), 2);
        sel = 2'd1; #1 chk("eot_instr", 64'(rd0), 2);
        sel = 2'd0; #1 chk("eot_cyc", 64'(rd0), 1);
        a7 = 0; mis = 1; snap = 1; repeat (3) step();
        sel = 2'd1; #1 chk("eot_frozen_instr", 64'(rd0), 2);
        sel = 2'd3; #1 chk("eot_frozen_mis", 64'(rd0), 0);
        chk("eot_frozen_state", 64'(st0), 2);
        // End of test, failing
        quiet(); clr = 1; step(); clr = 0;
        chk("eot_clr_done", 64'(done0), 0);
        chk("eot_clr_pass", 64'(pass0), 0);
        en = 1; step();
        a7 = 32'h5D; a0 = 7; step();
        chk("eot2_done", 64'(done0), 1);
        chk("eot2_pass", 64'(pass0), 0);

        // Priority: clear beats snapshot, end match and events
        quiet(); clr = 1; step(); clr = 0;
        en = 1; step();
        v = 2'b11; step(); snap = 1; step(); snap = 0;
        sel = 2'd1; #1 chk("pri_pre_rd", 64'(rd0), 4);
        clr = 1; snap = 1; a7 = 32'h5D; step();
        chk("pri_state", 64'(st0), 0);
        chk("pri_done", 64'(done0), 0);
        chk("pri_shadow", 64'(rd0), 0);
        quiet(); snap = 1; step(); snap = 0;
        chk("pri_live_instr", 64'(rd0), 0);
        sel = 2'd0; #1 chk("pri_live_cyc", 64'(rd0), 0);

        // Pause: en low for five cycles mid-run
        quiet(); clr = 1; step(); clr = 0;
        en = 1; step();
        chk("pause_run", 64'(st0), 1);
        repeat (5) step();
        en = 0; step();
        chk("pause_idle", 64'(st0), 0);
        repeat (4) step();
        en = 1; step();
        chk("pause_resume", 64'(st0), 1);
        repeat (5) step();
        en = 0; snap = 1; sel = 2'd0; step(); snap = 0;
        chk("pause_cyc", 64'(rd0), 10);

        // Asynchronous reset mid-run
        quiet(); clr = 1; step(); clr = 0;
        en = 1; step();
        v = 2'b11; snap = 1; sel = 2'd1; repeat (3) step();
        chk("arst_pre_rd", 64'(rd0), 6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 64'(st0), 0);
        chk("arst_rd", 64'(rd0), 0);
        chk("arst_ovf", 64'(ovf0), 0);
        chk("arst_done", 64'(done0), 0);
        #10 rst_n = 1'b1;
        quiet(); step();

        // Random run against the model
        clr = 1; model_step(); step(); clr = 0;
        for (int n = 0; n < 3000; n++) begin
            v = 2'($urandom); f = 2'($urandom); b = 2'($urandom);
            mis = ($urandom_range(0, 3) == 0);
            en = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 399) == 0);
            snap = ($urandom_range(0, 7) == 0);
            a7 = ($urandom_range(0, 299) == 0) ? 32'h5D : $urandom;
            a0 = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
            sel = 2'($urandom);
            model_step();
            step();
            chk_dut(0, 64'(rd0), ovf0, st0, done0, pass0);
            chk_dut(1, 64'(rd1), ovf1, st1, done1, pass1);
            chk_dut(2, 64'(rd2), ovf2, st2, done2, pass2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/perf_event_counter.md
# perf_event_counter

Synthesizable performance-monitoring block for the superscalar RISC-V core, sitting beside the ROB and decode stage. It replaces bench-only commit, branch and mispredict counting with counters that are parametrised in commit width and counter width. It adds overflow handling, a shadow snapshot bank with a read port, and an end-of-test detector (`a7 == 0x5D`) that freezes the counters and latches pass/fail.

## Interface
- `COMMIT_W`, default 2: number of ROB commit ports; range 1..8.
- `CNT_W`, default 32: width of every counter; range 8..64.
- `SAT`, default 0: overflow mode. 0 = wrap and set sticky overflow; 1 = saturate at all-ones and set sticky overflow.
- `END_CODE`, default 32'h5D: `a7` value that marks end of test.

- `clk` in 1: the block's single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `commit_valid_i` in COMMIT_W: per-port commit valid.
- `commit_flushed_i` in COMMIT_W: per-port flushed flag; a flushed commit is not counted.
- `commit_branch_i` in COMMIT_W: per-port committed-instruction-is-branch.
- `mispredict_i` in 1: one-cycle pulse from decode `must_flush`.
- `en_i` in 1: counting enable, level.
- `clr_i` in 1: synchronous clear.
- `snap_i` in 1: copy the live counters into the shadow bank.
- `a7_i` in 32: architectural x17.
- `a0_i` in 32: architectural x10.
- `sel_i` in 2: shadow read select. 0 = cycle, 1 = instr, 2 = branch, 3 = mispredict.
- `rd_data_o` out CNT_W: shadow counter selected by `sel_i`.
- `ovf_o` out 4: sticky overflow flags, indexed the same way as `sel_i`.
- `state_o` out 2: 0 = IDLE, 1 = RUN, 2 = DONE.
- `done_o` out 1: high while in DONE.
- `pass_o` out 1: latched result, `a0_i == 0` at DONE entry.

## Operation
- Live counters:
  - cyc: +1 per RUN cycle.
  - instr: + popcount(`commit_valid_i & ~commit_flushed_i`).
  - br: + popcount(`commit_valid_i & ~commit_flushed_i & commit_branch_i`).
  - mis: +1 per `mispredict_i`.
- Increment width is `$clog2(COMMIT_W+1)`, zero-extended before the add.
- Counters update only when state is RUN and `en_i` is high. In every other case all live counters hold their value.
- Overflow when the true sum exceeds 2^CNT_W−1:
  - SAT=0: the counter takes the sum mod 2^CNT_W.
  - SAT=1: the counter becomes all-ones.
  - In both modes the matching `ovf_o` bit sets and stays set until `clr_i` or reset.
- FSM:
  - IDLE → RUN when `en_i` is 1.
  - RUN → IDLE when `en_i` is 0; counters are retained.
  - RUN → DONE when `a7_i == END_CODE`. The increments of that same cycle are applied.
  - DONE is terminal. Counters stay frozen, and `snap_i` and `en_i` are ignored.
  - Any state → IDLE on `clr_i`.
- On DONE entry, the shadow bank automatically captures the post-increment live values, and `pass_o` latches `a0_i == 0`.
- `snap_i` in IDLE or RUN loads the shadow bank with the next-state live values, so increments from that cycle are included.
- `clr_i` has the highest priority. It zeroes live counters, shadow, `ovf_o` and `pass_o`, and forces IDLE. It wins over simultaneous `snap_i`, end detection or events.
- `rd_data_o` is a combinational mux of the shadow bank; live counters are not directly readable.

## Timing
- Reset (async assert, sync-to-`clk` deassert): all counters, shadow and `ovf_o` are 0, `state_o` = IDLE, and `done_o` = `pass_o` = 0.
- Events sampled at edge N appear in the live counters after edge N.
- A snapshot at edge N makes `rd_data_o` valid in cycle N+1, and `sel_i` to `rd_data_o` is zero-latency.
- With `a7_i` matching at edge N, `done_o`, `pass_o` and the shadow bank are valid from cycle N+1. There is no further counting after edge N.
- `en_i` low at edge N means no increment at N; the state is IDLE from N+1.
- Reset asserted mid-RUN or mid-DONE clears everything immediately, regardless of the clock.
- Commit ports are symmetric: any subset may be valid in a cycle, including all COMMIT_W.

## Test plan
- Count and report: COMMIT_W=2, `en_i`=1 for 10 cycles, both ports valid and unflushed every cycle, port 0 is a branch on 3 of those cycles, 2 `mispredict_i` pulses, then `snap_i`. Required reads: sel0=10, sel1=20, sel2=3, sel3=2.
- Flush masking: `commit_valid_i`=2'b11 with `commit_flushed_i`=2'b10 for 4 cycles → instr=4. Repeat with `commit_valid_i`=2'b01 and `commit_flushed_i`=2'b01 → instr unchanged.
- Overflow: CNT_W=8. Preload instr to 254, then commit 2 per cycle for 2 cycles. SAT=0 → instr=2 and `ovf_o[1]`=1. SAT=1 → instr=255 and `ovf_o[1]`=1. `ovf_o[1]` stays 1 until `clr_i`.
- End of test: `a7_i`=0x5D with `a0_i`=0 and 2 commits in the same cycle. Next cycle: `done_o`=1, `pass_o`=1, shadow instr includes those 2. Further events and `snap_i` change nothing. Repeat with `a0_i`=7 → `pass_o`=0.
- Priority and reset: `clr_i`, `snap_i` and an end match in the same cycle → IDLE with all counters 0 and `done_o`=0. `rst_n` low mid-RUN → all outputs 0 asynchronously.
- Pause: drop `en_i` for 5 cycles mid-run → cyc advances by exactly 5 fewer than wall cycles, and the state returns to RUN one edge after `en_i` rises.
